// File: rtl/te_pair_sequencer_pkg.sv
// Shared constants and FSM encoding for the tracklet-engine pair sequencer.
package te_pair_sequencer_pkg;

  localparam int DEF_ADDR_W     = 6;   // per-BX stub index width (MEM_SIZE)
  localparam int DEF_BX_W       = 5;
  localparam int DEF_MAX_PAIRS  = 64;
  localparam int DEF_DONE_DELAY = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-latency shift register; flush empties the in-flight stages while still accepting din.
module pipe_delay #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [STAGES];

  // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= din;
      for (int k = 1; k < STAGES; k++) pipe[k] <= flush ? '0 : pipe[k-1];
    end
  end

  assign dout = pipe[STAGES-1];

endmodule

// File: rtl/te_pair_sequencer_counter.sv
// Nested inner/outer index counter: j runs fastest, i advances when j wraps at n_outer-1.
module te_pair_counter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W:0]   n_inner,
  input  logic [ADDR_W:0]   n_outer,
  output logic [ADDR_W-1:0] idx_i,
  output logic [ADDR_W-1:0] idx_j,
  output logic              last
);

  logic j_wrap;

  assign j_wrap = ({1'b0, idx_j} + (ADDR_W+1)'(1)) == n_outer;
  assign last   = j_wrap && (({1'b0, idx_i} + (ADDR_W+1)'(1)) == n_inner);

  always_ff @(posedge clk) begin
    if (clear) begin
      idx_i <= '0;
      idx_j <= '0;
    end else if (step) begin
      if (j_wrap) begin
        idx_j <= '0;
        idx_i <= idx_i + ADDR_W'(1);
      end else begin
        idx_j <= idx_j + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/te_pair_sequencer.sv
// Per-BX (inner, outer) VMStub address walker with pair budget, stall and pipelined start/done.
module te_pair_sequencer
  import te_pair_sequencer_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BX_W       = DEF_BX_W,
  parameter int MAX_PAIRS  = DEF_MAX_PAIRS,
  parameter int DONE_DELAY = DEF_DONE_DELAY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_proc,
  input  logic [1:0]             start,
  output logic [1:0]             done,
  input  logic [5:0]             number_in_innervmstubin,
  input  logic [5:0]             number_in_outervmstubin,
  output logic [BX_W+ADDR_W-1:0] read_add_innervmstubin,
  output logic [BX_W+ADDR_W-1:0] read_add_outervmstubin,
  output logic                   pair_valid,
  output logic                   busy,
  output logic                   truncated
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int PC_W  = $clog2(MAX_PAIRS + 1);

  function automatic logic [CNT_W-1:0] clamp_count(input logic [5:0] n);
    if (int'(n) > (1 << ADDR_W)) return CNT_W'(1 << ADDR_W);
    return CNT_W'(n);
  endfunction

  state_t            state;
  logic [BX_W-1:0]   bx;
  logic [CNT_W-1:0]  n_inner;
  logic [CNT_W-1:0]  n_outer;
  logic [PC_W-1:0]   pc;
  logic [ADDR_W-1:0] idx_i;
  logic [ADDR_W-1:0] idx_j;
  logic              last_pair;
  logic              budget_hit;
  logic              finish;
  logic              cnt_clear;
  logic              cnt_step;
  logic              has_pairs;

  assign has_pairs  = (number_in_innervmstubin != '0) && (number_in_outervmstubin != '0);
  assign budget_hit = pc == PC_W'(MAX_PAIRS - 1);
  // The visible pair is consumed on this edge; stop if it was the last one or used up the budget.
  assign finish     = (state == RUN) && pair_valid && (last_pair || budget_hit);
  assign cnt_clear  = reset || start[1] || start[0];
  assign cnt_step   = (state == RUN) && pair_valid && !finish;

  te_pair_counter #(.ADDR_W(ADDR_W)) u_counter (
    .clk     (clk),
    .clear   (cnt_clear),
    .step    (cnt_step),
    .n_inner (n_inner),
    .n_outer (n_outer),
    .idx_i   (idx_i),
    .idx_j   (idx_j),
    .last    (last_pair)
  );

  always_ff @(posedge clk) begin
    if (reset || start[1]) begin
      state      <= IDLE;
      bx         <= '1;
      n_inner    <= '0;
      n_outer    <= '0;
      pc         <= '0;
      pair_valid <= 1'b0;
      truncated  <= 1'b0;
    end else if (start[0]) begin
      bx         <= bx + BX_W'(1);
      n_inner    <= clamp_count(number_in_innervmstubin);
      n_outer    <= clamp_count(number_in_outervmstubin);
      pc         <= '0;
      truncated  <= (state == RUN);
      state      <= has_pairs ? RUN : IDLE;
      pair_valid <= has_pairs;
    end else begin
      truncated <= 1'b0;
      if (state == RUN) begin
        if (finish) begin
          state      <= IDLE;
          pair_valid <= 1'b0;
          pc         <= pc + PC_W'(1);
          truncated  <= !last_pair;
        end else begin
          if (pair_valid) pc <= pc + PC_W'(1);
          pair_valid <= en_proc;
        end
      end
    end
  end

  assign busy                   = (state == RUN);
  assign read_add_innervmstubin = {bx, idx_i};
  assign read_add_outervmstubin = {bx, idx_j};

  pipe_delay #(.STAGES(DONE_DELAY), .WIDTH(2)) u_done (
    .clk   (clk),
    .reset (reset),
    .flush (start[1]),
    .din   (start),
    .dout  (done)
  );

endmodule

// File: tb/tb_te_pair_sequencer.sv
// Scoreboard bench: a list-based reference model queues expected pairs and control values; a monitor compares.
module tb_te_pair_sequencer;

  localparam int ADDR_W     = 6;
  localparam int BX_W       = 5;
  localparam int MAX_PAIRS  = 64;
  localparam int DONE_DELAY = 5;

  typedef struct {
    int bx;
    int i;
    int j;
  } pair_t;

  typedef struct {
    bit pv;
    bit busy;
    bit trunc;
    int done;
    bit addr_known;
    int addr;
  } ctrl_t;

  logic                   clk;
  logic                   reset;
  logic                   en_proc;
  logic [1:0]             start;
  logic [1:0]             done;
  logic [5:0]             n_in;
  logic [5:0]             n_out;
  logic [BX_W+ADDR_W-1:0] add_in;
  logic [BX_W+ADDR_W-1:0] add_out;
  logic                   pair_valid;
  logic                   busy;
  logic                   truncated;

  int checks = 0;
  int errors = 0;

  pair_t exp_pairs[$];
  ctrl_t exp_ctrl[$];

  int    m_bx      = 31;
  pair_t m_rem[$];
  bit    m_busy    = 0;
  bit    m_visible = 0;
  bit    m_cut     = 0;
  int    m_done_q[$];

  te_pair_sequencer #(
    .ADDR_W(ADDR_W), .BX_W(BX_W), .MAX_PAIRS(MAX_PAIRS), .DONE_DELAY(DONE_DELAY)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .en_proc                 (en_proc),
    .start                   (start),
    .done                    (done),
    .number_in_innervmstubin (n_in),
    .number_in_outervmstubin (n_out),
    .read_add_innervmstubin  (add_in),
    .read_add_outervmstubin  (add_out),
    .pair_valid              (pair_valid),
    .busy                    (busy),
    .truncated               (truncated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue();
    exp_pairs.push_back(m_rem.pop_front());
    m_visible = 1;
  endtask

  // Reference: each BX is the row-major list of (i,j) pairs, cut to the budget;
  // one list entry appears per enabled cycle after the first, which appears right after start.
  task automatic model_edge(input bit rst, input bit [1:0] st, input int ni, input int no, input bit en);
    ctrl_t c = '{default: 0};
    int    ci, co, total;
    if (rst) begin
      m_done_q.delete();
      repeat (DONE_DELAY) m_done_q.push_back(0);
    end else if (st[1]) begin
      m_done_q.delete();
      repeat (DONE_DELAY - 1) m_done_q.push_back(0);
      m_done_q.push_back(int'(st));
    end else begin
      void'(m_done_q.pop_front());
      m_done_q.push_back(int'(st));
    end
    c.done = m_done_q[0];

    if (rst || st[1]) begin
      m_bx = 31;
      m_rem.delete();
      m_busy = 0;
      m_visible = 0;
      c.addr_known = 1;
      c.addr = 31 << ADDR_W;
    end else if (st[0]) begin
      c.trunc = m_busy;
      m_bx = (m_bx + 1) % (1 << BX_W);
      ci = (ni > (1 << ADDR_W)) ? (1 << ADDR_W) : ni;
      co = (no > (1 << ADDR_W)) ? (1 << ADDR_W) : no;
      total = (ci * co > MAX_PAIRS) ? MAX_PAIRS : ci * co;
      m_cut = (ci * co > MAX_PAIRS);
      m_rem.delete();
      for (int k = 0; k < total; k++) m_rem.push_back('{m_bx, k / co, k % co});
      if (total > 0) begin
        issue();
        m_busy = 1;
      end else begin
        m_busy = 0;
        m_visible = 0;
      end
    end else if (m_busy) begin
      if (m_visible && m_rem.size() == 0) begin
        m_busy = 0;
        m_visible = 0;
        c.trunc = m_cut;
      end else if (en) begin
        issue();
      end else begin
        m_visible = 0;
      end
    end
    c.pv = m_visible;
    c.busy = m_busy;
    exp_ctrl.push_back(c);
  endtask

  task automatic step(input bit rst, input bit [1:0] st, input int ni, input int no, input bit en);
    reset = rst;
    start = st;
    en_proc = en;
    n_in = 6'(ni);
    n_out = 6'(no);
    model_edge(rst, st, ni, no, en);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 2'b00, 0, 0, 1);
  endtask

  initial begin : monitor
    ctrl_t c;
    pair_t p;
    forever begin
      @(negedge clk);
      if (exp_ctrl.size() > 0) begin
        c = exp_ctrl.pop_front();
        check("pair_valid", 32'(pair_valid), 32'(c.pv));
        check("busy", 32'(busy), 32'(c.busy));
        check("truncated", 32'(truncated), 32'(c.trunc));
        check("done", 32'(done), 32'(c.done));
        if (c.addr_known) begin
          check("reset_addr_inner", 32'(add_in), 32'(c.addr));
          check("reset_addr_outer", 32'(add_out), 32'(c.addr));
        end
        if (pair_valid === 1'b1) begin
          if (exp_pairs.size() == 0) begin
            check("unexpected_pair", 32'(1), 32'(0));
          end else begin
            p = exp_pairs.pop_front();
            check("addr_inner", 32'(add_in), 32'((p.bx << ADDR_W) | p.i));
            check("addr_outer", 32'(add_out), 32'((p.bx << ADDR_W) | p.j));
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit [1:0] st;
    int       ni, no;
    reset = 1'b1;
    start = 2'b00;
    en_proc = 1'b1;
    n_in = '0;
    n_out = '0;

    step(1, 2'b00, 0, 0, 1);
    step(1, 2'b00, 0, 0, 1);
    idle(2);

    // 2x3 walk, then an empty BX
    step(0, 2'b01, 2, 3, 1);
    idle(9);
    step(0, 2'b01, 0, 5, 1);
    idle(8);

    // budget cut at 64 pairs
    step(0, 2'b01, 10, 10, 1);
    idle(70);

    // 4x4 with a three-cycle stall after the fifth pair
    step(0, 2'b01, 4, 4, 1);
    repeat (4) step(0, 2'b00, 0, 0, 1);
    repeat (3) step(0, 2'b00, 0, 0, 0);
    idle(16);

    // new BX aborts a running loop
    step(0, 2'b01, 5, 5, 1);
    idle(2);
    step(0, 2'b01, 1, 2, 1);
    idle(5);

    // bx wrap over 33 strobes, then pipelined reset mid-run
    for (int k = 0; k < 33; k++) step(0, 2'b01, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1);
    idle(3);
    step(0, 2'b01, 3, 7, 1);
    idle(4);
    step(0, 2'b10, 0, 0, 1);
    idle(8);

    for (int k = 0; k < 3000; k++) begin
      st[0] = ($urandom_range(0, 19) == 0);
      st[1] = ($urandom_range(0, 149) == 0);
      ni = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9));
      no = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9));
      step($urandom_range(0, 599) == 0, st, ni, no, $urandom_range(0, 4) != 0);
    end

    idle(80);
    @(negedge clk);
    #1;
    check("pairs_outstanding", 32'(exp_pairs.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
